// File: rtl/dmem_responder.sv
// Memory-side responder for the core's data port: combinational word reads,
// byte-lane word writes, and fixed-latency 256-bit block read/write requests.
//
//   state | meaning
//   IDLE  | waiting for a block request (write wins over read)
//   RBUSY | block read in flight, cnt counts down to completion
//   WBUSY | block write in flight, data latched, commit at cnt == 0
//   DONE  | valid pulse cycle, requests ignored, back to IDLE
module dmem_responder #(
  parameter int ADDR_BITS   = 10,
  parameter int BLK_LATENCY = 4
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [31:0]  data_address_2DM,
  input  logic         MemRead_2DM,
  input  logic         MemWrite_2DM,
  input  logic [31:0]  data_write_2DM,
  input  logic [1:0]   data_write_size_2DM,
  output logic [31:0]  data_read_fDM,
  input  logic [255:0] block_write_2DM,
  input  logic         dBlkRead,
  input  logic         dBlkWrite,
  output logic [255:0] block_read_fDM,
  output logic         block_read_fDM_valid,
  output logic         block_write_fDM_valid
);

  localparam int WORDS    = 1 << ADDR_BITS;
  localparam int BLK_BITS = ADDR_BITS - 3;
  localparam int CNT_W    = (BLK_LATENCY > 1) ? $clog2(BLK_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(BLK_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, RBUSY, WBUSY, DONE} state_t;

  logic [31:0]          mem [WORDS];
  logic [ADDR_BITS-1:0] word_idx;
  logic [BLK_BITS-1:0]  blk_idx;
  logic [1:0]           lane_off;
  logic [2:0]           n_bytes;
  logic [31:0]          wr_word;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic                 take_req, take_wr, rd_done, wr_done;
  logic [BLK_BITS-1:0]  blk_addr;
  logic [255:0]         blk_wdata;
  logic [255:0]         blk_rdata;
  logic                 unused_addr;

  assign word_idx    = data_address_2DM[ADDR_BITS+1:2];
  assign blk_idx     = data_address_2DM[ADDR_BITS+1:5];
  assign lane_off    = data_address_2DM[1:0];
  assign n_bytes     = (data_write_size_2DM == 2'd0) ? 3'd4 : {1'b0, data_write_size_2DM};
  assign unused_addr = ^data_address_2DM[31:ADDR_BITS+2];

  assign data_read_fDM = (MemRead_2DM && RESET) ? mem[word_idx] : 32'h0;

  // Big-endian lane merge: lane 0 is bits 31:24; lanes past 3 fall off the word.
  always_comb begin
    wr_word = mem[word_idx];
    for (int l = 0; l < 4; l++) begin
      if (l >= int'(lane_off) && l < int'(lane_off) + int'(n_bytes))
        wr_word[31-8*l -: 8] = data_write_2DM[8*(int'(n_bytes) - 1 - l + int'(lane_off)) +: 8];
    end
  end

  always_comb begin
    blk_rdata = '0;
    for (int i = 0; i < 8; i++)
      blk_rdata[255-32*i -: 32] = mem[{blk_addr, 3'(i)}];
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    take_req  = 1'b0;
    take_wr   = 1'b0;
    rd_done   = 1'b0;
    wr_done   = 1'b0;
    case (state)
      IDLE: begin
        if (dBlkWrite) begin
          state_nxt = WBUSY;
          cnt_nxt   = CNT_INIT;
          take_req  = 1'b1;
          take_wr   = 1'b1;
        end else if (dBlkRead) begin
          state_nxt = RBUSY;
          cnt_nxt   = CNT_INIT;
          take_req  = 1'b1;
        end
      end
      RBUSY: begin
        if (cnt != '0) cnt_nxt = cnt - 1'b1;
        else begin
          rd_done   = 1'b1;
          state_nxt = DONE;
        end
      end
      WBUSY: begin
        if (cnt != '0) cnt_nxt = cnt - 1'b1;
        else begin
          wr_done   = 1'b1;
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state                 <= IDLE;
      cnt                   <= '0;
      block_read_fDM_valid  <= 1'b0;
      block_write_fDM_valid <= 1'b0;
      block_read_fDM        <= '0;
    end else begin
      state                 <= state_nxt;
      cnt                   <= cnt_nxt;
      block_read_fDM_valid  <= rd_done;
      block_write_fDM_valid <= wr_done;
      if (rd_done) block_read_fDM <= blk_rdata;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET && take_req) blk_addr  <= blk_idx;
    if (RESET && take_wr)  blk_wdata <= block_write_2DM;
  end

  // Block commit is placed after the word write so it wins on a shared edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      if (MemWrite_2DM) mem[word_idx] <= wr_word;
      if (wr_done) begin
        mem[{blk_addr, 3'd0}] <= blk_wdata[255:224];
        mem[{blk_addr, 3'd1}] <= blk_wdata[223:192];
        mem[{blk_addr, 3'd2}] <= blk_wdata[191:160];
        mem[{blk_addr, 3'd3}] <= blk_wdata[159:128];
        mem[{blk_addr, 3'd4}] <= blk_wdata[127:96];
        mem[{blk_addr, 3'd5}] <= blk_wdata[95:64];
        mem[{blk_addr, 3'd6}] <= blk_wdata[63:32];
        mem[{blk_addr, 3'd7}] <= blk_wdata[31:0];
      end
    end
  end

endmodule
